// File: rtl/pmem_arbiter.sv
// Purpose: shares one physical-memory port between the I-cache (line reads) and the D-cache (line reads/writebacks).
// Latency: grant one cycle after a request is seen in IDLE; the cache resp is pmem_resp passed through in the same cycle.
// Backpressure: one transaction at a time; a waiting requester simply holds its command until it gets resp.
// Optional feature: define PMEM_ARB_ROUND_ROBIN_EN for round-robin contention resolution (default: D-cache wins).
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              grant_d
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t              state_q, state_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                d_req, i_req, pick_d;

  assign d_req = dcache_pmem_read | dcache_pmem_write;
  assign i_req = icache_pmem_read;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // 1 when the D-cache received the most recent grant
  logic last_d_q, last_d_d;

  // Contention goes to whichever requester was not served last
  always_comb begin
    pick_d = d_req & (~i_req | ~last_d_q);
  end
`else
  // Fixed priority: the D-cache always wins contention
  always_comb begin
    pick_d = d_req;
  end
`endif

  // Next-state and grant-time capture of the winner's command/address/data.
  // The command is held in registers so a requester dropping its request
  // mid-transaction cannot disturb the memory-side command.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = SERVE_D;
          // read+write together is illegal; treat it as a write
          rd_d    = ~dcache_pmem_write;
          wr_d    = dcache_pmem_write;
          addr_d  = dcache_pmem_address;
          wdata_d = dcache_pmem_wdata;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`endif
        end else if (i_req) begin
          state_d = SERVE_I;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          addr_d  = icache_pmem_address;
          wdata_d = '0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
          last_d_d = 1'b0;
`endif
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
      end
    endcase
  end

  // State and registered memory-side command; reset abandons any transaction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign grant_d      = (state_q == SERVE_D);

  // Completion passes straight through to the owner only
  assign icache_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign dcache_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

endmodule
